// File: rtl/time_set_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// time_set_pkg: shared state, field encoding and range helpers
// Rev 1.0
// ----------------------------------------------------------------
package time_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EDIT_HRS = 3'd1,
    ST_EDIT_MIN = 3'd2,
    ST_EDIT_SEC = 3'd3,
    ST_COMMIT   = 3'd4
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HRS  = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam logic [4:0] MAX_HRS    = 5'd23;
  localparam logic [5:0] MAX_MINSEC = 6'd59;

  // Wrapping steps; any out-of-range input lands back inside the range.
  function automatic logic [4:0] step_hrs(input logic [4:0] val, input logic up);
    if (up) return (val >= MAX_HRS) ? 5'd0 : val + 5'd1;
    else    return (val == 5'd0 || val > MAX_HRS) ? MAX_HRS : val - 5'd1;
  endfunction

  function automatic logic [5:0] step_minsec(input logic [5:0] val, input logic up);
    if (up) return (val >= MAX_MINSEC) ? 6'd0 : val + 6'd1;
    else    return (val == 6'd0 || val > MAX_MINSEC) ? MAX_MINSEC : val - 6'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------
// button_conditioner: 2-flop sync, debounce, one-cycle press pulse
// Rev 1.0
// ----------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int              c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1, r_sync2, r_prev;
  logic               r_stable, r_stable_d, r_armed, r_press;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_settled;

  assign w_settled = r_armed && (r_sync2 == r_stable);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Until a debounced low is seen after reset the button is unarmed, so a
  // button held through reset release must be released before it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_armed  <= 1'b0;
    end else if (w_settled || (!r_armed && (r_sync2 != r_prev))) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt    <= '0;
      r_stable <= r_sync2;
      if (!r_sync2) r_armed <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_press    <= r_armed & r_stable & ~r_stable_d;
    end
  end

  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/time_setter.sv
`default_nettype none
// ----------------------------------------------------------------
// time_setter: button-driven hh:mm:ss editor with commit strobe
// Rev 1.0
// ----------------------------------------------------------------
module time_setter
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_set,
  output logic [4:0] sethrs,
  output logic [5:0] setmin,
  output logic [5:0] setsec,
  output logic [1:0] field_sel,
  output logic       load,
  output logic       blink
);

  localparam int                 c_blk_w    = $clog2(BLINK_CYCLES + 1);
  localparam logic [c_blk_w-1:0] c_blk_last = c_blk_w'(BLINK_CYCLES - 1);

  logic w_next_p, w_up_p, w_down_p, w_set_p;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst_n(rst_n), .raw(btn_next), .press(w_next_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst_n(rst_n), .raw(btn_up), .press(w_up_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst_n(rst_n), .raw(btn_down), .press(w_down_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk(clk), .rst_n(rst_n), .raw(btn_set), .press(w_set_p));

  state_t             r_state, w_state_nxt, w_field_next;
  logic [4:0]         r_hrs;
  logic [5:0]         r_min, r_sec;
  logic [1:0]         r_field_sel, w_field_sel_nxt;
  logic               r_load, w_load_nxt, w_editing_nxt;
  logic               r_blink, w_blink_restart;
  logic [c_blk_w-1:0] r_blk_cnt;
  logic               w_in_edit, w_adjust;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    case (r_state)
      ST_EDIT_HRS: w_field_next = ST_EDIT_MIN;
      ST_EDIT_MIN: w_field_next = ST_EDIT_SEC;
      default:     w_field_next = ST_EDIT_HRS;
    endcase
  end

  // Dropping enable outranks set, so leaving setup mode never loads.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (enable) w_state_nxt = ST_EDIT_HRS;
      ST_EDIT_HRS, ST_EDIT_MIN, ST_EDIT_SEC: begin
        if (!enable)       w_state_nxt = ST_IDLE;
        else if (w_set_p)  w_state_nxt = ST_COMMIT;
        else if (w_next_p) w_state_nxt = w_field_next;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_field_sel_nxt = FIELD_NONE;
    w_load_nxt      = 1'b0;
    w_editing_nxt   = 1'b0;
    case (w_state_nxt)
      ST_EDIT_HRS: begin w_field_sel_nxt = FIELD_HRS; w_editing_nxt = 1'b1; end
      ST_EDIT_MIN: begin w_field_sel_nxt = FIELD_MIN; w_editing_nxt = 1'b1; end
      ST_EDIT_SEC: begin w_field_sel_nxt = FIELD_SEC; w_editing_nxt = 1'b1; end
      ST_COMMIT:   w_load_nxt = 1'b1;
      default:     ;
    endcase
  end

  assign w_blink_restart = w_editing_nxt && (w_state_nxt != r_state);
  assign w_in_edit = (r_state == ST_EDIT_HRS) || (r_state == ST_EDIT_MIN) ||
                     (r_state == ST_EDIT_SEC);
  assign w_adjust  = w_in_edit && enable && !w_set_p && !w_next_p &&
                     (w_up_p ^ w_down_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_field_sel <= FIELD_NONE;
      r_load      <= 1'b0;
    end else begin
      r_field_sel <= w_field_sel_nxt;
      r_load      <= w_load_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hrs <= '0;
      r_min <= '0;
      r_sec <= '0;
    end else if (w_adjust) begin
      case (r_state)
        ST_EDIT_HRS: r_hrs <= step_hrs(r_hrs, w_up_p);
        ST_EDIT_MIN: r_min <= step_minsec(r_min, w_up_p);
        ST_EDIT_SEC: r_sec <= step_minsec(r_sec, w_up_p);
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt <= '0;
      r_blink   <= 1'b0;
    end else if (!w_editing_nxt) begin
      r_blk_cnt <= '0;
      r_blink   <= 1'b0;
    end else if (w_blink_restart) begin
      r_blk_cnt <= '0;
      r_blink   <= 1'b1;
    end else if (r_blk_cnt == c_blk_last) begin
      r_blk_cnt <= '0;
      r_blink   <= ~r_blink;
    end else begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  assign sethrs    = r_hrs;
  assign setmin    = r_min;
  assign setsec    = r_sec;
  assign field_sel = r_field_sel;
  assign load      = r_load;
  assign blink     = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_time_setter.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_time_setter: directed and random button sequences vs. time model
// Rev 1.0
// ----------------------------------------------------------------
module tb_time_setter;

  localparam int DEB = 4;
  localparam int BLK = 8;

  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic       btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_set = 1'b0;
  logic [4:0] sethrs;
  logic [5:0] setmin, setsec;
  logic [1:0] field_sel;
  logic       load, blink;

  int errors = 0, checks = 0, load_cnt = 0;
  // Reference: current time fields, selected field (0 = not editing), commits.
  int m_h = 0, m_m = 0, m_s = 0, m_field = 0, m_loads = 0;

  time_setter #(.DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down), .btn_set(btn_set),
    .sethrs(sethrs), .setmin(setmin), .setsec(setsec),
    .field_sel(field_sel), .load(load), .blink(blink));

  always #5 clk = ~clk;

  always @(posedge clk) if (load === 1'b1) load_cnt <= load_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".field"}, {30'd0, field_sel}, m_field);
    check({tag, ".hrs"},   {27'd0, sethrs},    m_h);
    check({tag, ".min"},   {26'd0, setmin},    m_m);
    check({tag, ".sec"},   {26'd0, setsec},    m_s);
    check({tag, ".loads"}, load_cnt,           m_loads);
  endtask

  task automatic model_press(input bit s, input bit n, input bit u, input bit d);
    int step;
    if (m_field == 0) return;
    if (s) begin
      m_loads++;
      m_field = 0;
    end else if (n) begin
      m_field = (m_field == 3) ? 1 : m_field + 1;
    end else if (u != d) begin
      step = u ? 1 : -1;
      case (m_field)
        1: m_h = (m_h + 24 + step) % 24;
        2: m_m = (m_m + 60 + step) % 60;
        default: m_s = (m_s + 60 + step) % 60;
      endcase
    end
  endtask

  // On a set press the bench drops enable as soon as load appears, so the
  // block settles in IDLE instead of re-entering edit.
  task automatic press(input bit s, input bit n, input bit u, input bit d,
                       input int hold, input string tag);
    btn_set = s; btn_next = n; btn_up = u; btn_down = d;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (s && load === 1'b1) enable = 1'b0;
    end
    btn_set = 0; btn_next = 0; btn_up = 0; btn_down = 0;
    repeat (12) @(negedge clk);
    model_press(s, n, u, d);
    check_all(tag);
  endtask

  task automatic enter(input string tag);
    enable = 1'b1;
    @(negedge clk);
    m_field = 1;
    check({tag, ".field"}, {30'd0, field_sel}, 1);
    check({tag, ".blink"}, {31'd0, blink}, 1);
  endtask

  initial begin
    int r, hold;
    repeat (3) @(negedge clk);
    check("rst.hrs", {27'd0, sethrs}, 0);
    check("rst.min", {26'd0, setmin}, 0);
    check("rst.sec", {26'd0, setsec}, 0);
    check("rst.field", {30'd0, field_sel}, 0);
    check("rst.load", {31'd0, load}, 0);
    check("rst.blink", {31'd0, blink}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    press(0, 0, 1, 0, 10, "idle_up");

    enter("enter1");
    repeat (7) @(negedge clk);
    check("blink.hi", {31'd0, blink}, 1);
    @(negedge clk);
    check("blink.lo", {31'd0, blink}, 0);

    press(0, 0, 1, 0, 10, "up1");
    press(0, 0, 1, 0, 10, "up2");
    press(0, 0, 1, 0, 10, "up3");
    press(0, 1, 0, 0, 10, "next_min");
    press(0, 0, 0, 1, 10, "min_down");
    press(1, 0, 0, 0, 10, "commit1");
    check("commit1.hrs3", {27'd0, sethrs}, 3);
    check("commit1.min59", {26'd0, setmin}, 59);

    enter("enter2");
    press(0, 0, 0, 1, 10, "hdn1");
    press(0, 0, 0, 1, 10, "hdn2");
    press(0, 0, 0, 1, 10, "hdn3");
    press(0, 0, 0, 1, 10, "h0_down");
    check("h0_down.23", {27'd0, sethrs}, 23);
    press(0, 0, 1, 0, 10, "h23_up");
    press(0, 1, 0, 0, 10, "to_min");
    press(0, 1, 0, 0, 10, "to_sec");
    press(0, 0, 0, 1, 10, "s0_down");
    press(0, 0, 1, 0, 10, "s59_up");
    press(0, 1, 0, 0, 10, "to_hrs");

    // Bouncing up button: short glitches must be rejected.
    btn_up = 1; repeat (2) @(negedge clk);
    btn_up = 0; repeat (2) @(negedge clk);
    btn_up = 1; repeat (1) @(negedge clk);
    btn_up = 0; repeat (2) @(negedge clk);
    btn_up = 1; repeat (10) @(negedge clk);
    btn_up = 0; repeat (12) @(negedge clk);
    model_press(0, 0, 1, 0);
    check_all("bounce");

    press(0, 1, 1, 0, 10, "next_up");
    press(1, 0, 1, 0, 10, "set_up");

    enter("enter3");
    press(0, 1, 0, 0, 10, "to_min2");
    enable = 1'b0;
    repeat (2) @(negedge clk);
    m_field = 0;
    check_all("en_drop");
    enable = 1'b1;
    repeat (2) @(negedge clk);
    m_field = 1;
    check_all("en_back");

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 5);
      hold = $urandom_range(8, 14);
      case (r)
        0, 1:    press(0, 0, 1, 0, hold, "rnd_up");
        2, 3:    press(0, 0, 0, 1, hold, "rnd_dn");
        4:       press(0, 1, 0, 0, hold, "rnd_next");
        default: press(0, 0, 1, 1, hold, "rnd_updn");
      endcase
    end
    press(1, 0, 0, 0, 10, "commit2");

    // Reset mid-edit with up held through release.
    enter("enter4");
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst.hrs", {27'd0, sethrs}, 0);
    check("arst.min", {26'd0, setmin}, 0);
    check("arst.sec", {26'd0, setsec}, 0);
    check("arst.field", {30'd0, field_sel}, 0);
    check("arst.load", {31'd0, load}, 0);
    check("arst.blink", {31'd0, blink}, 0);
    m_h = 0; m_m = 0; m_s = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    m_field = 1;
    check_all("held_up");
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    check_all("held_rel");
    press(0, 0, 1, 0, 10, "repress");
    check("repress.hrs1", {27'd0, sethrs}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
